// File: rtl/inv_cipher.sv
// AES inverse cipher (FIPS-197) for 128/192/256-bit keys.
// The key schedule is expanded one word per cycle, then one round is applied per cycle.
module inv_cipher #(
    parameter int unsigned nk = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic [127:0]      state_in,
    input  logic [nk*32-1:0]  initial_key,
    output logic [127:0]      state_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned nr = nk + 6;
    localparam int unsigned nw = 4 * (nr + 1);

    typedef enum logic [2:0] {StIdle, StKeyExp, StInit, StRound, StFinal} state_e;

    state_e       state_q, state_d;
    logic [31:0]  w_q [nw];
    logic [5:0]   word_q;
    logic [2:0]   kmod_q;
    logic [7:0]   rcon_q;
    logic [3:0]   round_q;
    logic [127:0] s_q;
    logic [127:0] out_q;
    logic         done_q;

    // ---------------- GF(2^8) helpers (polynomial 0x11B) ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // x^254 is the multiplicative inverse; zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int k = 0; k < 7; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int k);
        return (a << k) | (a >> (8 - k));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] a;
        a = gf_inv(x);
        return a ^ rotl8(a, 1) ^ rotl8(a, 2) ^ rotl8(a, 3) ^ rotl8(a, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // ---------------- State transforms (byte n at bits [127-8n -: 8]) ----------------
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32 * c -: 32] = inv_mix_col(s[127 - 32 * c -: 32]);
        end
        return o;
    endfunction

    // ---------------- Key expansion word ----------------
    logic [31:0] prev_w, far_w, temp_w, new_w;

    always_comb begin
        prev_w = w_q[word_q - 6'd1];
        far_w  = w_q[word_q - 6'(nk)];
        if (kmod_q == 3'd0) begin
            temp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h000000};
        end else if (nk == 8 && kmod_q == 3'd4) begin
            temp_w = sub_word(prev_w);
        end else begin
            temp_w = prev_w;
        end
        new_w = far_w ^ temp_w;
    end

    // ---------------- Round datapath ----------------
    logic [3:0]   rk_sel;
    logic [5:0]   rk_base;
    logic [127:0] round_key;
    logic [127:0] inv_core;

    always_comb begin
        rk_sel    = (state_q == StInit) ? 4'(nr) : round_q;
        rk_base   = {rk_sel, 2'b00};
        round_key = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
        inv_core  = inv_sub_bytes(inv_shift_rows(s_q)) ^ round_key;
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StKeyExp;
            StKeyExp: if (word_q == 6'(nw - 1)) state_d = StInit;
            StInit:   state_d = StRound;
            StRound:  if (round_q == 4'd1) state_d = StFinal;
            StFinal:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q  <= '0;
            kmod_q  <= '0;
            rcon_q  <= '0;
            round_q <= '0;
            s_q     <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else if (enable) begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        s_q    <= state_in;
                        word_q <= 6'(nk);
                        kmod_q <= '0;
                        rcon_q <= 8'h01;
                    end
                end
                StKeyExp: begin
                    word_q <= word_q + 6'd1;
                    kmod_q <= (kmod_q == 3'(nk - 1)) ? 3'd0 : kmod_q + 3'd1;
                    if (kmod_q == 3'd0) rcon_q <= xtime(rcon_q);
                end
                StInit: begin
                    s_q     <= s_q ^ round_key;
                    round_q <= 4'(nr - 1);
                end
                StRound: begin
                    s_q     <= inv_mix_columns(inv_core);
                    round_q <= round_q - 4'd1;
                end
                StFinal: begin
                    out_q  <= inv_core;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Key array carries no reset: every start reloads w[0..nk-1] before it is read.
    always_ff @(posedge clk) begin
        if (!reset && enable) begin
            if (state_q == StIdle && start) begin
                for (int j = 0; j < int'(nk); j++) begin
                    w_q[j] <= initial_key[(int'(nk) - 1 - j) * 32 +: 32];
                end
            end else if (state_q == StKeyExp) begin
                w_q[word_q] <= new_w;
            end
        end
    end

    assign state_out = out_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule
